mem_arbiter: RTL and testbench

//  Shares the single RAM port between icache (read-only) and dcache (read/write).

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/arb_beat_ctr.sv | 30 +++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the icache/dcache RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int unsigned BURST_LEN_DEF = 2;

  // A one-beat burst still needs a 1-bit counter to keep the port legal.
  function automatic int unsigned beat_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_beat_ctr.sv
// Beat counter for one grant: counts completed beats, clears on release,
// flags the final beat of the burst.
module arb_beat_ctr
  import mem_arb_pkg::*;
#(
  parameter  int unsigned BURST_LEN = BURST_LEN_DEF,
  localparam int unsigned BW        = beat_w(BURST_LEN)
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_beat,
  input  logic i_clr,
  output logic o_last
);

  logic [BW-1:0] r_beat;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_beat <= '0;
    end else if (i_clr) begin
      r_beat <= '0;
    end else if (i_beat) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  assign o_last = (r_beat == BW'(BURST_LEN - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between icache (read) and dcache (read/write),
// holding each grant for a BURST_LEN-beat block. Define ARB_RR_EN for round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic [1:0]    ramstate
);

  arb_state_t r_state;
  arb_state_t w_pick;
  logic       w_dreq;
  logic       w_access;
  logic       w_holder_req;
  logic       w_beat;
  logic       w_last;
  logic       w_rel_a;
  logic       w_release;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate_t'(ramstate) == ACCESS);

  always_comb begin
    w_holder_req = 1'b0;
    case (r_state)
      IGNT:    w_holder_req = iREN;
      DGNT:    w_holder_req = w_dreq;
      default: w_holder_req = 1'b0;
    endcase
  end

  assign w_beat    = w_holder_req & w_access;
  assign w_rel_a   = w_beat & w_last;
  assign w_release = (r_state != IDLE) & (w_rel_a | ~w_holder_req);

  arb_beat_ctr #(.BURST_LEN(BURST_LEN)) u_beat_ctr (
    .clk    (CLK),
    .nrst   (nRST),
    .i_beat (w_beat),
    .i_clr  (w_release),
    .o_last (w_last)
  );

`ifdef ARB_RR_EN
  grant_t r_last_grant;
  grant_t w_last_eff;

  // A burst finishing this cycle counts as the latest grant for the handover choice.
  assign w_last_eff = w_rel_a ? ((r_state == DGNT) ? GNT_D : GNT_I) : r_last_grant;

  always_comb begin
    w_pick = IDLE;
    if (w_dreq && iREN)  w_pick = (w_last_eff == GNT_D) ? IGNT : DGNT;
    else if (w_dreq)     w_pick = DGNT;
    else if (iREN)       w_pick = IGNT;
  end

  always_ff @(posedge CLK) begin
    if (!nRST)        r_last_grant <= GNT_I;
    else if (w_rel_a) r_last_grant <= w_last_eff;
  end
`else
  always_comb begin
    w_pick = IDLE;
    if (w_dreq)     w_pick = DGNT;
    else if (iREN)  w_pick = IGNT;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else if ((r_state == IDLE) || w_release) begin
      r_state <= w_pick;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = daddr;
    ramstore = dstore;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~w_access;
      end
      DGNT: begin
        ramWEN = dWEN;
        ramREN = dREN & ~dWEN;
        dwait  = ~w_access;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: each vector carries the hand-derived
// grant state; a negedge monitor pops expected port values and compares.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] RF = 2'd0, RB = 2'd1, RA = 2'd2, RE = 2'd3;
  localparam int G_IDLE = 0, G_I = 1, G_D = 2;

  typedef struct {
    string       nm;
    logic        ren, wen, iw, dw;
    logic [31:0] addr, store, load;
  } exp_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [AW-1:0] iaddr = '0, daddr = '0;
  logic [DW-1:0] dstore = '0, ramload = '0;
  logic [1:0]    ramstate = 2'd0;
  logic          iwait, dwait, ramREN, ramWEN;
  logic [DW-1:0] iload, dload, ramstore;
  logic [AW-1:0] ramaddr;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_arbiter #(.BURST_LEN(2), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // g is the grant state the arbiter must hold during this cycle.
  task automatic step(input string nm, input bit rn, input bit ir, input bit dr,
                      input bit dw, input logic [1:0] rs, input int g);
    exp_t e;
    @(posedge CLK);
    #1;
    cyc      = cyc + 1;
    nRST     = rn;
    iREN     = ir;
    dREN     = dr;
    dWEN     = dw;
    iaddr    = 32'h0000_1000 + 32'(cyc * 4);
    daddr    = 32'h0000_8000 + 32'(cyc * 4);
    dstore   = 32'hD500_0000 + 32'(cyc);
    ramload  = 32'hCAFE_0000 + 32'(cyc);
    ramstate = rs;
    e.nm    = nm;
    e.store = dstore;
    e.load  = ramload;
    e.ren   = 1'b0;
    e.wen   = 1'b0;
    e.iw    = 1'b1;
    e.dw    = 1'b1;
    e.addr  = daddr;
    if (g == G_I) begin
      e.ren  = ir;
      e.addr = iaddr;
      e.iw   = (rs != RA);
    end else if (g == G_D) begin
      e.wen = dw;
      e.ren = dr & ~dw;
      e.dw  = (rs != RA);
    end
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total = total + 1;
      if (ramREN !== e.ren || ramWEN !== e.wen || iwait !== e.iw || dwait !== e.dw ||
          ramaddr !== e.addr || ramstore !== e.store || iload !== e.load || dload !== e.load) begin
        bad = bad + 1;
        $display("FAIL %s: got ren=%b wen=%b iw=%b dw=%b addr=%h store=%h iload=%h dload=%h; want ren=%b wen=%b iw=%b dw=%b addr=%h store=%h load=%h",
                 e.nm, ramREN, ramWEN, iwait, dwait, ramaddr, ramstore, iload, dload,
                 e.ren, e.wen, e.iw, e.dw, e.addr, e.store, e.load);
      end
    end
  end

  initial begin
    step("rst0", 0, 1, 1, 0, RA, G_IDLE);
    step("rst1", 0, 1, 1, 0, RA, G_IDLE);
    step("rst_rel", 1, 0, 0, 0, RA, G_IDLE);
`ifdef ARB_RR_EN
    step("rr_req", 1, 1, 1, 0, RA, G_IDLE);
    for (int k = 0; k < 2; k++) begin
      step("rr_d0", 1, 1, 1, 0, RA, G_D);
      step("rr_d1", 1, 1, 1, 0, RA, G_D);
      step("rr_i0", 1, 1, 1, 0, RA, G_I);
      step("rr_i1", 1, 1, 1, 0, RA, G_I);
    end
    step("rr_end", 1, 0, 0, 0, RF, G_D);
    step("rr_idle", 1, 0, 0, 0, RF, G_IDLE);
`else
    step("i_req", 1, 1, 0, 0, RA, G_IDLE);
    step("i_b0", 1, 1, 0, 0, RA, G_I);
    step("i_b1", 1, 1, 0, 0, RA, G_I);
    step("i_drop", 1, 0, 0, 0, RF, G_I);
    step("i_idle", 1, 0, 0, 0, RF, G_IDLE);

    step("dw_req", 1, 1, 0, 1, RA, G_IDLE);
    step("dw_b0", 1, 1, 0, 1, RA, G_D);
    step("dw_b1", 1, 1, 0, 1, RA, G_D);
    step("dw_drop", 1, 1, 0, 0, RB, G_D);
    step("hand_i", 1, 1, 0, 0, RA, G_I);
    step("hand_i_drop", 1, 0, 0, 0, RF, G_I);
    step("t3_idle", 1, 0, 0, 0, RF, G_IDLE);

    step("dr_req", 1, 0, 1, 0, RB, G_IDLE);
    for (int k = 0; k < 3; k++) step("d_busy", 1, 0, 1, 0, RB, G_D);
    step("d_acc0", 1, 0, 1, 0, RA, G_D);
    step("d_acc1", 1, 0, 1, 0, RA, G_D);
    step("d_drop", 1, 0, 0, 0, RF, G_D);
    step("t4_idle", 1, 0, 0, 0, RF, G_IDLE);

    step("i_req2", 1, 1, 0, 0, RF, G_IDLE);
    for (int k = 0; k < 3; k++) step("i_pend_busy", 1, 1, 1, 0, RB, G_I);
    step("i_pend_a0", 1, 1, 1, 0, RA, G_I);
    step("i_pend_a1", 1, 1, 1, 0, RA, G_I);
    step("d_after_i", 1, 1, 1, 0, RA, G_D);
    step("d_drop_i", 1, 1, 0, 0, RF, G_D);
    step("t5_i", 1, 1, 0, 0, RF, G_I);
    step("t5_idrop", 1, 0, 1, 0, RF, G_I);
    step("t5_d0", 1, 0, 1, 0, RA, G_D);
    step("t5_ddrop", 1, 0, 0, 0, RA, G_D);
    step("t5_idle", 1, 0, 0, 0, RA, G_IDLE);

    step("e_req", 1, 0, 1, 0, RE, G_IDLE);
    step("err0", 1, 0, 1, 0, RE, G_D);
    step("err1", 1, 0, 1, 0, RE, G_D);
    step("err_drop", 1, 0, 0, 0, RE, G_D);
    step("e_idle", 1, 0, 0, 0, RE, G_IDLE);

    step("mb_req", 1, 1, 0, 0, RA, G_IDLE);
    step("mb_b0", 1, 1, 0, 0, RA, G_I);
    step("mb_rst", 0, 1, 0, 0, RA, G_I);
    step("mb_after", 1, 1, 0, 0, RA, G_IDLE);
    step("mb_b0b", 1, 1, 1, 0, RA, G_I);
    step("mb_b1", 1, 1, 1, 0, RA, G_I);
    step("mb_d", 1, 0, 1, 0, RF, G_D);
    step("mb_ddrop", 1, 0, 0, 0, RF, G_D);
    step("mb_idle", 1, 0, 0, 0, RF, G_IDLE);
`endif
    repeat (3) @(posedge CLK);
    if (sb.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
